// File: rtl/io_responder.sv
// io_responder: memory-mapped I/O register block on the IO side of the CPU
// memory virtualizer. Holds the display and LED output registers, brings the
// switches and keys into the clock domain (keys are debounced, with sticky
// press flags), and provides a prescaled compare timer with an interrupt.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   rst          asynchronous active-high reset
//   addressIO    register index (one 32-bit register per index)
//   dataInIO     write data
//   wEnIO        write strobe, sampled at the clock edge
//   dataOutIO    read data, combinational from addressIO and registered state
//   sw           raw asynchronous switches
//   key_n        raw active-low bouncing keys
//   display_out  value feeding the display peripheral
//   led_out      LED drive
//   irq          timer interrupt (expired AND irq enable)
//
// Register map:
//   0 DISPLAY     RW
//   1 LED         RW, low NUM_SW bits
//   2 SWITCHES    RO, synchronised switches
//   3 KEYS        RO, debounced, 1 = pressed
//   4 KEY_EDGE    W1C sticky press flags
//   5 TIMER_COUNT RO
//   6 TIMER_CMP   RW
//   7 TIMER_CTRL  bit0 enable, bit1 auto-reload, bit2 expired (W1C),
//                 bit3 clear (write-only), bit4 irq enable
//   8..15 read 0, writes ignored
module io_responder #(
    parameter int IO_ADDR_BITS    = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int PRESCALE        = 50,
    parameter int NUM_SW          = 10,
    parameter int NUM_KEY         = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [IO_ADDR_BITS-1:0] addressIO,
    input  logic [31:0]             dataInIO,
    input  logic                    wEnIO,
    output logic [31:0]             dataOutIO,
    input  logic [NUM_SW-1:0]       sw,
    input  logic [NUM_KEY-1:0]      key_n,
    output logic [31:0]             display_out,
    output logic [NUM_SW-1:0]       led_out,
    output logic                    irq
);

    localparam int CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);

    // Register state
    logic [31:0]        display_q;
    logic [NUM_SW-1:0]  led_q;
    logic [NUM_SW-1:0]  sw_p0, sw_p1;
    logic [NUM_KEY-1:0] key_p0, key_p1;
    logic [NUM_KEY-1:0] key_state;
    logic [NUM_KEY-1:0] key_edge;
    logic [CNT_W-1:0]   key_cnt [NUM_KEY];
    logic [PRESC_W-1:0] presc;
    logic [31:0]        timer_count;
    logic [31:0]        timer_cmp;
    logic               ctrl_en;
    logic               ctrl_reload;
    logic               ctrl_irq_en;
    logic               expired;

    // Write decode
    logic wr_display, wr_led, wr_key_edge, wr_cmp, wr_ctrl;
    logic ctrl_clear;
    logic tick;
    logic exp_set, exp_w1c;
    logic [NUM_KEY-1:0] key_rise;
    logic [NUM_KEY-1:0] key_w1c;

    assign wr_display  = wEnIO && (addressIO == IO_ADDR_BITS'(0));
    assign wr_led      = wEnIO && (addressIO == IO_ADDR_BITS'(1));
    assign wr_key_edge = wEnIO && (addressIO == IO_ADDR_BITS'(4));
    assign wr_cmp      = wEnIO && (addressIO == IO_ADDR_BITS'(6));
    assign wr_ctrl     = wEnIO && (addressIO == IO_ADDR_BITS'(7));

    assign ctrl_clear = wr_ctrl && dataInIO[3];
    assign exp_w1c    = wr_ctrl && dataInIO[2];
    assign key_w1c    = wr_key_edge ? dataInIO[NUM_KEY-1:0] : '0;

    // A clear in the same cycle swallows the tick entirely.
    assign tick    = ctrl_en && (presc == PRESC_LAST) && !ctrl_clear;
    assign exp_set = tick && (timer_count == timer_cmp);

    // A debounced press is the cycle where the counter expires on a 0->1 change.
    always_comb begin
        key_rise = '0;
        for (int i = 0; i < NUM_KEY; i++) begin
            key_rise[i] = key_p1[i] && !key_state[i] && (key_cnt[i] == CNT_LAST);
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            display_q <= '0;
            led_q     <= '0;
        end else begin
            if (wr_display) display_q <= dataInIO;
            if (wr_led)     led_q     <= dataInIO[NUM_SW-1:0];
        end
    end

    // Stage p0 -> p1: two-flop synchronisers for switches and inverted keys
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_p0  <= '0;
            sw_p1  <= '0;
            key_p0 <= '0;
            key_p1 <= '0;
        end else begin
            sw_p0  <= sw;
            sw_p1  <= sw_p0;
            key_p0 <= ~key_n;
            key_p1 <= key_p0;
        end
    end

    // Debounce: any cycle where the synchronised key matches the debounced
    // state restarts the window, so a single bounce resets the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_state <= '0;
            key_edge  <= '0;
            for (int i = 0; i < NUM_KEY; i++) begin
                key_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_KEY; i++) begin
                if (key_p1[i] == key_state[i]) begin
                    key_cnt[i] <= '0;
                end else if (key_cnt[i] == CNT_LAST) begin
                    key_state[i] <= key_p1[i];
                    key_cnt[i]   <= '0;
                end else begin
                    key_cnt[i] <= key_cnt[i] + CNT_W'(1);
                end
            end
            // Set wins over a same-cycle clear.
            key_edge <= (key_edge & ~key_w1c) | key_rise;
        end
    end

    // Timer: prescaler, compare counter, control and expired flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc       <= '0;
            timer_count <= '0;
            timer_cmp   <= '0;
            ctrl_en     <= 1'b0;
            ctrl_reload <= 1'b0;
            ctrl_irq_en <= 1'b0;
            expired     <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en     <= dataInIO[0];
                ctrl_reload <= dataInIO[1];
                ctrl_irq_en <= dataInIO[4];
            end
            if (wr_cmp) timer_cmp <= dataInIO;

            if (ctrl_clear) begin
                presc       <= '0;
                timer_count <= '0;
            end else begin
                if (!ctrl_en || presc == PRESC_LAST) presc <= '0;
                else                                 presc <= presc + PRESC_W'(1);

                if (tick) begin
                    if (timer_count == timer_cmp) begin
                        if (ctrl_reload) timer_count <= '0;
                    end else begin
                        timer_count <= timer_count + 32'd1;
                    end
                end
            end

            // Set wins over a same-cycle clear.
            expired <= (expired && !exp_w1c) || exp_set;
        end
    end

    // Read mux: combinational so a load completes in the same cycle.
    always_comb begin
        dataOutIO = '0;
        case (addressIO)
            IO_ADDR_BITS'(0): dataOutIO = display_q;
            IO_ADDR_BITS'(1): dataOutIO = 32'(led_q);
            IO_ADDR_BITS'(2): dataOutIO = 32'(sw_p1);
            IO_ADDR_BITS'(3): dataOutIO = 32'(key_state);
            IO_ADDR_BITS'(4): dataOutIO = 32'(key_edge);
            IO_ADDR_BITS'(5): dataOutIO = timer_count;
            IO_ADDR_BITS'(6): dataOutIO = timer_cmp;
            IO_ADDR_BITS'(7): dataOutIO = {27'd0, ctrl_irq_en, 1'b0, expired,
                                           ctrl_reload, ctrl_en};
            default:          dataOutIO = '0;
        endcase
    end

    assign display_out = display_q;
    assign led_out     = led_q;
    assign irq         = expired && ctrl_irq_en;

endmodule

// File: tb/tb_io_responder.sv
// Directed testbench for io_responder with short debounce and prescale
// settings. Inputs are driven 1 time unit after the rising edge; outputs are
// read mid-cycle, away from the edge.
module tb_io_responder;

    logic        clk;
    logic        rst;
    logic [3:0]  addressIO;
    logic [31:0] dataInIO;
    logic        wEnIO;
    logic [31:0] dataOutIO;
    logic [9:0]  sw;
    logic [3:0]  key_n;
    logic [31:0] display_out;
    logic [9:0]  led_out;
    logic        irq;

    int n_cmp;
    int n_err;

    io_responder #(
        .IO_ADDR_BITS    (4),
        .DEBOUNCE_CYCLES (4),
        .PRESCALE        (2),
        .NUM_SW          (10),
        .NUM_KEY         (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .addressIO   (addressIO),
        .dataInIO    (dataInIO),
        .wEnIO       (wEnIO),
        .dataOutIO   (dataOutIO),
        .sw          (sw),
        .key_n       (key_n),
        .display_out (display_out),
        .led_out     (led_out),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        addressIO = a;
        dataInIO  = d;
        wEnIO     = 1'b1;
        @(posedge clk);
        #1;
        wEnIO     = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
        addressIO = a;
        #1;
        chk(tag, dataOutIO, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        addressIO = '0;
        dataInIO  = '0;
        wEnIO     = 1'b0;
        sw        = '0;
        key_n     = 4'hF;
        step(3);
        rst = 1'b0;

        // Reset state
        for (int i = 0; i < 16; i++) begin
            rd($sformatf("reset_rd%0d", i), 4'(i), 32'h0);
        end
        chk("reset_display", display_out, 32'h0);
        chk("reset_led", 32'(led_out), 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);

        // Display and LED registers
        wr(4'd0, 32'hDEADBEEF);
        rd("display_rd", 4'd0, 32'hDEADBEEF);
        chk("display_out", display_out, 32'hDEADBEEF);
        wr(4'd1, 32'hFFFFFFFF);
        chk("led_out", 32'(led_out), 32'h3FF);
        rd("led_rd", 4'd1, 32'h3FF);
        wr(4'd2, 32'hFFFFFFFF);
        rd("sw_ro", 4'd2, 32'h0);
        wr(4'd9, 32'h12345678);
        rd("unmapped_rd", 4'd9, 32'h0);
        chk("display_hold", display_out, 32'hDEADBEEF);

        // Switch synchroniser latency
        sw = 10'h155;
        step(1);
        rd("sw_1edge", 4'd2, 32'h0);
        step(1);
        rd("sw_2edge", 4'd2, 32'h155);

        // Key 1 bouncing: pressed two cycles, glitch released one cycle
        for (int r = 0; r < 4; r++) begin
            key_n[1] = 1'b0;
            step(2);
            key_n[1] = 1'b1;
            step(1);
            rd($sformatf("bounce_keys%0d", r), 4'd3, 32'h0);
        end
        rd("bounce_edge", 4'd4, 32'h0);

        // Stable press: debounced after 6 edges
        key_n[1] = 1'b0;
        step(5);
        rd("press_early", 4'd3, 32'h0);
        step(1);
        rd("press_keys", 4'd3, 32'h2);
        rd("press_edge", 4'd4, 32'h2);
        wr(4'd4, 32'h2);
        rd("edge_w1c", 4'd4, 32'h0);
        rd("keys_after_w1c", 4'd3, 32'h2);
        key_n[1] = 1'b1;
        step(8);
        rd("release_keys", 4'd3, 32'h0);
        rd("release_edge", 4'd4, 32'h0);

        // Timer, auto-reload: count advances every second edge
        wr(4'd6, 32'd3);
        wr(4'd7, 32'h13);
        rd("tmr_c0", 4'd5, 32'd0);
        step(2);
        rd("tmr_c1", 4'd5, 32'd1);
        step(2);
        rd("tmr_c2", 4'd5, 32'd2);
        step(2);
        rd("tmr_c3", 4'd5, 32'd3);
        chk("tmr_irq_pre", 32'(irq), 32'h0);
        step(2);
        rd("tmr_reload", 4'd5, 32'd0);
        rd("tmr_ctrl_exp", 4'd7, 32'h17);
        chk("tmr_irq", 32'(irq), 32'h1);
        wr(4'd7, 32'h17);
        rd("tmr_exp_w1c", 4'd7, 32'h13);
        chk("tmr_irq_clr", 32'(irq), 32'h0);

        // Timer, no auto-reload: holds at compare value
        wr(4'd7, 32'h08);
        rd("tmr_clear", 4'd5, 32'd0);
        wr(4'd7, 32'h11);
        step(8);
        rd("tmr_hold", 4'd5, 32'd3);
        rd("tmr_hold_ctrl", 4'd7, 32'h15);
        step(4);
        rd("tmr_hold2", 4'd5, 32'd3);
        chk("tmr_hold_irq", 32'(irq), 32'h1);
        wr(4'd7, 32'h19);
        rd("tmr_clr_cnt", 4'd5, 32'd0);
        rd("tmr_clr_ctrl", 4'd7, 32'h15);
        step(2);
        rd("tmr_resume", 4'd5, 32'd1);

        // Expired set coinciding with W1C; CMP=0 with auto-reload
        wr(4'd6, 32'd0);
        wr(4'd7, 32'h0C);
        rd("exp_cleared", 4'd7, 32'h00);
        wr(4'd7, 32'h13);
        step(1);
        wr(4'd7, 32'h17);
        rd("exp_set_wins", 4'd7, 32'h17);
        rd("cmp0_cnt", 4'd5, 32'd0);
        wr(4'd7, 32'h17);
        rd("exp_w1c_again", 4'd7, 32'h13);
        step(1);
        rd("cmp0_every_tick", 4'd7, 32'h17);
        rd("cmp0_cnt2", 4'd5, 32'd0);

        // KEY_EDGE set coinciding with W1C
        key_n[0] = 1'b0;
        step(5);
        rd("kedge_pre", 4'd4, 32'h0);
        wr(4'd4, 32'h1);
        rd("kedge_set_wins", 4'd4, 32'h1);
        rd("kedge_keys", 4'd3, 32'h1);

        // Asynchronous reset mid-count
        wr(4'd6, 32'd100);
        step(6);
        rd("pre_rst_cnt", 4'd5, 32'd3);
        chk("pre_rst_irq", 32'(irq), 32'h1);
        rst = 1'b1;
        #1;
        chk("rst_display", display_out, 32'h0);
        chk("rst_led", 32'(led_out), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        rd("rst_cnt", 4'd5, 32'h0);
        rd("rst_keys", 4'd3, 32'h0);
        rd("rst_ctrl", 4'd7, 32'h0);
        step(2);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
